// File: rtl/channel_waveform_renderer_pkg.sv
// Shared display geometry and capture-state encoding for the channel waveform renderer.
package channel_waveform_renderer_pkg;

    localparam int VGA_HOR_RES          = 640;
    localparam int VGA_VER_RES          = 480;
    localparam int SAMPLE_WIDTH_DEFAULT = 8;
    localparam int ROW_W                = $clog2(VGA_VER_RES);
    localparam int COL_W                = $clog2(VGA_HOR_RES);

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } cap_state_t;

endpackage

// File: rtl/channel_waveform_renderer_sample_bank_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, contents not reset.
module channel_waveform_renderer_sample_bank_ram #(
    parameter int ADDR_W = 15,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/channel_waveform_renderer.sv
// Waveform trace renderer: double-buffered per-channel sample capture plus a 2-cycle pixel test pipeline.
// Defining CHANNEL_GRID_EN also draws each channel's separator row and dashed centre row.
module channel_waveform_renderer
    import channel_waveform_renderer_pkg::*;
#(
    parameter int MAX_CHAN_COUNT = 10,
    parameter int SAMPLE_WIDTH   = SAMPLE_WIDTH_DEFAULT,
    parameter int CH_W           = $clog2(MAX_CHAN_COUNT)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MAX_CHAN_COUNT-1:0] channel_enable,
    input  logic                      sample_valid,
    input  logic [CH_W-1:0]           sample_channel,
    input  logic [SAMPLE_WIDTH-1:0]   sample_data,
    output logic                      sample_ready,
    input  logic                      frame_start,
    input  logic                      pixel_valid,
    input  logic [COL_W-1:0]          pixel_col,
    input  logic [ROW_W-1:0]          pixel_row,
    input  logic                      is_channel,
    input  logic [CH_W-1:0]           channel_number,
    input  logic [ROW_W-1:0]          channel_height,
    input  logic [ROW_W-1:0]          channel_offset,
    output logic                      pixel_on,
    output logic                      pixel_on_valid,
    output logic                      bank_swapped
);

    localparam int               ADDR_W   = 1 + CH_W + COL_W;
    localparam logic [COL_W-1:0] LINE_LEN = COL_W'(VGA_HOR_RES);

    cap_state_t       state;
    logic             write_bank;
    logic             display_bank;
    logic             display_valid;
    logic [COL_W-1:0] wr_ptr [MAX_CHAN_COUNT];
    logic             accept;
    logic             all_full_next;
    logic [SAMPLE_WIDTH-1:0] rd_data;

    assign display_bank = ~write_bank;

    // Completion looks at the pointers as they will be after this cycle's write.
    always_comb begin
        sample_ready = !reset && (state == FILL) && (32'(sample_channel) < MAX_CHAN_COUNT)
                     && channel_enable[sample_channel] && (wr_ptr[sample_channel] < LINE_LEN);
        accept        = sample_valid && sample_ready;
        all_full_next = |channel_enable;
        for (int c = 0; c < MAX_CHAN_COUNT; c++) begin
            if (channel_enable[c] && !((wr_ptr[c] == LINE_LEN) ||
                (accept && 32'(sample_channel) == c && wr_ptr[c] == LINE_LEN - COL_W'(1)))) begin
                all_full_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= FILL;
            write_bank    <= 1'b0;
            display_valid <= 1'b0;
            bank_swapped  <= 1'b0;
            for (int c = 0; c < MAX_CHAN_COUNT; c++) begin
                wr_ptr[c] <= '0;
            end
        end else begin
            bank_swapped <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        wr_ptr[sample_channel] <= wr_ptr[sample_channel] + COL_W'(1);
                    end
                    if (all_full_next) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (frame_start) begin
                        write_bank    <= ~write_bank;
                        display_valid <= 1'b1;
                        bank_swapped  <= 1'b1;
                        state         <= FILL;
                        for (int c = 0; c < MAX_CHAN_COUNT; c++) begin
                            wr_ptr[c] <= '0;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    channel_waveform_renderer_sample_bank_ram #(
        .ADDR_W(ADDR_W),
        .WIDTH (SAMPLE_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (accept),
        .wr_addr({write_bank, sample_channel, wr_ptr[sample_channel]}),
        .wr_data(sample_data),
        .rd_addr({display_bank, channel_number, pixel_col}),
        .rd_data(rd_data)
    );

    // Screen row of a sample: top of the channel band is offset, larger samples sit higher.
    function automatic logic [ROW_W:0] trace_row_of(input logic [SAMPLE_WIDTH-1:0] s,
                                                   input logic [ROW_W-1:0] h,
                                                   input logic [ROW_W-1:0] off);
        logic [SAMPLE_WIDTH+ROW_W-1:0] prod;
        prod = (SAMPLE_WIDTH+ROW_W)'(s) * (SAMPLE_WIDTH+ROW_W)'(h);
        return (ROW_W+1)'(off) + (ROW_W+1)'(h) - (ROW_W+1)'(1) - (ROW_W+1)'(prod >> SAMPLE_WIDTH);
    endfunction

    logic             vld_p0, isch_p0, dv_p0, first_p0;
    logic [ROW_W-1:0] row_p0, height_p0, offset_p0;
    logic [ROW_W:0]   prev_row;
    logic [ROW_W:0]   trace_p1, prev_p1, lo_p1, hi_p1;
    logic             hit_p1;
`ifdef CHANNEL_GRID_EN
    logic             col2_p0;
`endif

    // Stage 1: RAM data is valid; build the segment from the previous trace row to this one.
    always_comb begin
        trace_p1 = trace_row_of(rd_data, height_p0, offset_p0);
        prev_p1  = first_p0 ? trace_p1 : prev_row;
        lo_p1    = (prev_p1 < trace_p1) ? prev_p1 : trace_p1;
        hi_p1    = (prev_p1 < trace_p1) ? trace_p1 : prev_p1;
        hit_p1   = dv_p0 && isch_p0 && vld_p0 && (height_p0 != '0)
                 && ({1'b0, row_p0} >= lo_p1) && ({1'b0, row_p0} <= hi_p1);
`ifdef CHANNEL_GRID_EN
        if (isch_p0 && vld_p0 && ((row_p0 == offset_p0) ||
            (({1'b0, row_p0} == {1'b0, offset_p0} + {2'b0, height_p0[ROW_W-1:1]}) && !col2_p0))) begin
            hit_p1 = 1'b1;
        end
`endif
    end

    // Stage 0 captures the pixel alongside the RAM read; stage 2 registers the decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0         <= 1'b0;
            isch_p0        <= 1'b0;
            dv_p0          <= 1'b0;
            first_p0       <= 1'b0;
            row_p0         <= '0;
            height_p0      <= '0;
            offset_p0      <= '0;
            prev_row       <= '0;
            pixel_on       <= 1'b0;
            pixel_on_valid <= 1'b0;
`ifdef CHANNEL_GRID_EN
            col2_p0        <= 1'b0;
`endif
        end else begin
            vld_p0         <= pixel_valid;
            isch_p0        <= is_channel;
            dv_p0          <= display_valid;
            first_p0       <= (pixel_col == '0);
            row_p0         <= pixel_row;
            height_p0      <= channel_height;
            offset_p0      <= channel_offset;
            if (vld_p0) begin
                prev_row <= trace_p1;
            end
            pixel_on       <= hit_p1;
            pixel_on_valid <= vld_p0;
`ifdef CHANNEL_GRID_EN
            col2_p0        <= pixel_col[2];
`endif
        end
    end

endmodule

// File: tb/tb_channel_waveform_renderer.sv
// Scoreboard bench for channel_waveform_renderer: random capture/pixel traffic against a behavioural model.
module tb_channel_waveform_renderer;
    import channel_waveform_renderer_pkg::*;

    localparam int NCH = 10;
    localparam int HOR = VGA_HOR_RES;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   channel_enable = 10'b1;
    logic             sample_valid = 1'b0;
    logic [3:0]       sample_channel = '0;
    logic [7:0]       sample_data = '0;
    logic             sample_ready;
    logic             frame_start = 1'b0;
    logic             pixel_valid = 1'b0;
    logic [COL_W-1:0] pixel_col = '0;
    logic [ROW_W-1:0] pixel_row = '0;
    logic             is_channel = 1'b0;
    logic [3:0]       channel_number = '0;
    logic [ROW_W-1:0] channel_height = '0;
    logic [ROW_W-1:0] channel_offset = '0;
    logic             pixel_on, pixel_on_valid, bank_swapped;

    channel_waveform_renderer dut (
        .clk(clk), .reset(reset), .channel_enable(channel_enable),
        .sample_valid(sample_valid), .sample_channel(sample_channel), .sample_data(sample_data),
        .sample_ready(sample_ready), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .pixel_col(pixel_col), .pixel_row(pixel_row), .is_channel(is_channel),
        .channel_number(channel_number), .channel_height(channel_height),
        .channel_offset(channel_offset), .pixel_on(pixel_on), .pixel_on_valid(pixel_on_valid),
        .bank_swapped(bank_swapped)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: sample store per bank/channel (-1 = never written), fill counts, bank roles.
    int mem [2][NCH][HOR];
    int cnt [NCH];
    bit m_done, m_dv, exp_swap, m_prev_unknown;
    int m_wb, m_prev;
    int exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int trace_of(input int s, input int h, input int off);
        return off + h - 1 - (s * h) / 256;
    endfunction

    function automatic bit ready_model(input int sch);
        if (m_done || sch >= NCH) return 1'b0;
        return channel_enable[sch] && cnt[sch] < HOR;
    endfunction

    function automatic bit all_full();
        if (channel_enable == '0) return 1'b0;
        for (int c = 0; c < NCH; c++)
            if (channel_enable[c] && cnt[c] != HOR) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
        m_done = 0; m_dv = 0; m_wb = 0; exp_swap = 0;
        m_prev = 0; m_prev_unknown = 1;
    endtask

    // One clock of stimulus: called just after a rising edge, returns just after the next one.
    task automatic drive(input bit sv, input int sch, input int sdat, input bit fs,
                         input bit pv, input bit ic, input int cn, input int col,
                         input int row, input int h, input int off);
        bit rdy, known, e;
        int s, t, p, lo, hi;
        sample_valid = sv; sample_channel = 4'(sch); sample_data = 8'(sdat);
        frame_start = fs; pixel_valid = pv; is_channel = ic; channel_number = 4'(cn);
        pixel_col = COL_W'(col); pixel_row = ROW_W'(row);
        channel_height = ROW_W'(h); channel_offset = ROW_W'(off);
        rdy = ready_model(sch);
        if (pv) begin
            s = mem[1 - m_wb][cn][col];
            known = ic && h > 0 && s >= 0;
            t = known ? trace_of(s, h, off) : 0;
            p = (col == 0) ? t : m_prev;
            lo = (p < t) ? p : t;
            hi = (p < t) ? t : p;
            e = m_dv && known && (col == 0 || !m_prev_unknown) && row >= lo && row <= hi;
`ifdef CHANNEL_GRID_EN
            if (ic && (row == off || (row == off + h / 2 && (col & 4) == 0))) e = 1'b1;
`endif
            exp_q.push_back(int'(e));
            m_prev = t;
            m_prev_unknown = !known;
        end
        @(negedge clk);
        check("sample_ready", int'(sample_ready), int'(rdy));
        check("bank_swapped", int'(bank_swapped), int'(exp_swap));
        @(posedge clk);
        exp_swap = 0;
        if (m_done) begin
            if (fs) begin
                m_wb = 1 - m_wb; m_dv = 1; exp_swap = 1; m_done = 0;
                for (int c = 0; c < NCH; c++) cnt[c] = 0;
            end
        end else begin
            if (sv && rdy) begin
                mem[m_wb][sch][cnt[sch]] = sdat;
                cnt[sch]++;
            end
            m_done = all_full();
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame();
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
    endtask

    // mode 0: constant 128, mode 1: 0/255 alternating, mode 2: random. fs_at >= 0 pulses frame_start mid-fill.
    task automatic fill_chan(input int ch, input int mode, input int fs_at);
        int guard = 0;
        int d;
        while (cnt[ch] < HOR && guard < 3000) begin
            guard++;
            if (guard % 7 == 0) begin
                drive(1, (guard % 14 == 0) ? 1 : int'($urandom_range(10, 15)),
                      int'($urandom_range(0, 255)), 0, 0, 0, 0, 0, 0, 0, 0);
            end else begin
                d = (mode == 0) ? 128 : (mode == 1) ? ((cnt[ch] % 2) ? 255 : 0)
                                                    : int'($urandom_range(0, 255));
                drive(1, ch, d, (fs_at >= 0 && cnt[ch] == fs_at), 0, 0, 0, 0, 0, 0, 0);
            end
        end
        if (cnt[ch] < HOR) check("fill_timeout", cnt[ch], HOR);
    endtask

    task automatic scan_row(input int row, input int c0, input int c1, input int ch,
                            input int h, input int off);
        for (int c = c0; c <= c1; c++) begin
            if (c % 50 == 49) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 1, 1, ch, c, row, h, off);
        end
    endtask

    task automatic rand_pixels(input int n, input int chmask);
        int ch, h, off, row, col;
        bit ic;
        for (int i = 0; i < n; i++) begin
            do ch = int'($urandom_range(0, NCH - 1)); while (!chmask[ch]);
            ic  = ($urandom_range(0, 7) != 0);
            h   = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 240));
            off = int'($urandom_range(0, 480 - h));
            row = off + int'($urandom_range(0, h + 9)) - 5;
            if (row < 0) row = 0;
            if (row > 479) row = 479;
            col = m_prev_unknown ? 0 : int'($urandom_range(0, HOR - 1));
            if ($urandom_range(0, 9) == 0) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            else drive(0, 0, 0, 0, 1, ic, ch, col, row, h, off);
        end
    endtask

    // Monitor: every presented pixel result is checked against the oldest pending expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (pixel_on_valid === 1'b1) begin
                if (exp_q.size() == 0) check("pixel_on_unexpected", 1, 0);
                else check("pixel_on", int'(pixel_on), exp_q.pop_front());
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog at %0t: bench did not finish, got timeout, expected completion", $time);
        $fatal(1);
    end

    initial begin
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < NCH; c++)
                for (int x = 0; x < HOR; x++) mem[b][c][x] = -1;
        model_reset();

        #12;
        check("reset_pixel_on", int'(pixel_on), 0);
        check("reset_pixel_on_valid", int'(pixel_on_valid), 0);
        check("reset_sample_ready", int'(sample_ready), 0);
        check("reset_bank_swapped", int'(bank_swapped), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rand_pixels(40, 1);

        fill_chan(0, 0, 300);
        idle(2);
        frame();
        for (int r = 238; r <= 241; r++) scan_row(r, 0, HOR - 1, 0, 480, 0);

        fill_chan(0, 1, -1);
        idle(2);
        frame();
        for (int r = 0; r < 240; r++) scan_row(r, 0, 7, 0, 240, 0);

        channel_enable = 10'b101;
        fill_chan(0, 2, -1);
        idle(2);
        frame();
        fill_chan(2, 2, -1);
        idle(2);
        frame();
        scan_row(240, 0, 15, 2, 240, 240);
        scan_row(120, 0, 15, 0, 240, 0);
        rand_pixels(600, 10'b101);

        channel_enable = 10'b1;
        idle(2);
        for (int i = 0; i < 100; i++)
            drive(1, 0, int'($urandom_range(0, 255)), 0, 1, 1, 0, i,
                  int'($urandom_range(0, 239)), 240, 0);
        #1 reset = 1'b1;
        #1;
        check("async_reset_pixel_on", int'(pixel_on), 0);
        check("async_reset_pixel_on_valid", int'(pixel_on_valid), 0);
        check("async_reset_sample_ready", int'(sample_ready), 0);
        check("async_reset_bank_swapped", int'(bank_swapped), 0);
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        rand_pixels(30, 1);
        fill_chan(0, 2, -1);
        idle(2);
        frame();
        rand_pixels(200, 1);
        idle(4);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
